req_sequencer: RTL
==================

REQ_SEQUENCER -- requirements
Module: req_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the pending-request FIFO depth (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 8, SHALL set the maximum cycles req is held waiting for gnt (2..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 push  input  1  SHALL enqueue one request token when high and cmd_ready is high.
REQ-006 cmd_ready  output  1  SHALL equal NOT FIFO-full (combinational from state).
REQ-007 gnt  input  1  SHALL be the grant returned by the downstream req/gnt block.
REQ-008 req  output  1  SHALL be the registered request driven to the downstream block.
REQ-009 done  output  1  SHALL pulse one cycle per accepted grant.
REQ-010 timeout  output  1  SHALL pulse one cycle per abandoned request.
REQ-011 pending  output  $clog2(DEPTH)+1  SHALL report the FIFO occupancy.
REQ-012 grant_cnt  output  8  SHALL count accepted grants, saturating at 255.
REQ-013 spurious  output  1  SHALL be a sticky flag set when gnt=1 is sampled while req=0.

Function
REQ-014 FSM states SHALL be IDLE, REQ, GAP.
REQ-015 IDLE: if pending>0, SHALL pop one token, set req=1 next cycle, enter REQ; otherwise SHALL stay in IDLE with req=0.
REQ-016 REQ: a wait counter SHALL start at 0 and increment each cycle gnt=0 is sampled.
REQ-017 REQ, gnt=1 sampled: req SHALL be 0 on the following cycle, done=1 for that cycle, grant_cnt increments, and the FSM enters GAP.
REQ-018 REQ, gnt=0 with wait counter = TIMEOUT-1: req SHALL be 0 on the following cycle, timeout=1 for that cycle, and the FSM enters GAP.
REQ-019 GAP SHALL last exactly one cycle with req=0, then enter IDLE; back-to-back requests therefore have at least one low cycle of req between them.
REQ-020 Request-to-request spacing SHALL be: grant at cycle N gives req low at N+1 (GAP) and req high again at N+3 if pending>0 (IDLE pop at N+2).
REQ-021 A push while full SHALL be dropped with no state change; push and pop in the same cycle SHALL leave pending unchanged.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; pending SHALL never exceed DEPTH or underflow.
REQ-023 gnt sampled while req=0 (IDLE or GAP) SHALL be ignored by the FSM and SHALL set spurious.
REQ-024 grant_cnt at 255 SHALL hold 255 on further grants while done still pulses.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE and clear FIFO, wait counter, retry state, grant_cnt and spurious.
REQ-026 During reset, req, done and timeout SHALL be 0; cmd_ready SHALL be 1 and pending 0.
REQ-027 Reset asserted in REQ SHALL drop req on the next edge with no done or timeout pulse.

Configuration
REQ-028 With macro REQ_SEQUENCER_RETRY_EN defined, the first timeout of a token SHALL NOT pulse timeout; the FSM SHALL pass through GAP and re-issue the same token without popping, and only a second timeout SHALL pulse timeout and discard it.
REQ-029 Without REQ_SEQUENCER_RETRY_EN, every timeout SHALL discard the token immediately per REQ-018.

Verification
REQ-030 Reset, one push, gnt tied to req delayed one cycle: req high 2 cycles, done once, grant_cnt=1, pending=0.
REQ-031 Push 5 with DEPTH=4 and gnt=0: 4 accepted, fifth dropped, cmd_ready=0 while full, four timeouts each after 8 req-high cycles.
REQ-032 gnt held 1, 3 pushes: req pattern high,low(GAP),low(IDLE),high repeats; 3 done pulses; grant_cnt=3.
REQ-033 gnt pulse while idle: spurious=1 and stays 1; no done; FSM remains IDLE.
REQ-034 rst_n=0 mid-REQ at wait count 3: req=0 next cycle, pending=0, no done or timeout, grant_cnt=0.
REQ-035 RETRY_EN defined, gnt=0, 1 push: req high 8 cycles, 1 GAP cycle, 1 IDLE cycle, high 8 more cycles, then exactly one timeout pulse.

Source files
------------

// File: rtl/req_sequencer_if.sv
// Request-sequencer bus: command-side push/cmd_ready, downstream req/gnt,
// plus status outputs. The slave modport is the sequencer's view.
interface req_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic          push;
  logic          cmd_ready;
  logic          gnt;
  logic          req;
  logic          done;
  logic          timeout;
  logic [PW-1:0] pending;
  logic [7:0]    grant_cnt;
  logic          spurious;

  modport master (
    output push, gnt,
    input  cmd_ready, req, done, timeout, pending, grant_cnt, spurious
  );

  modport slave (
    input  push, gnt,
    output cmd_ready, req, done, timeout, pending, grant_cnt, spurious
  );
endinterface

// File: rtl/req_sequencer.sv
// Token FIFO feeding a req/gnt handshake with a bounded wait and a one-cycle gap.
// Optional macro REQ_SEQUENCER_RETRY_EN re-issues a timed-out token once before dropping it.
module req_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  req_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH) + 1;

`ifdef REQ_SEQUENCER_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t        state;
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] occ;
  logic [7:0]    wait_cnt;
  logic          retried;
  logic          req_r;
  logic          done_r;
  logic          timeout_r;
  logic          spurious_r;
  logic [7:0]    grant_cnt_r;
  logic          push_acc;
  logic          pop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign occ           = wr_ptr - rd_ptr;
  assign bus.cmd_ready = (occ != PW'(DEPTH));
  assign push_acc      = bus.push && bus.cmd_ready;
  // A pending retry re-issues the same token instead of consuming a new one.
  assign pop           = (state == IDLE) && !retried && (occ != '0);

  assign bus.req       = req_r;
  assign bus.done      = done_r;
  assign bus.timeout   = timeout_r;
  assign bus.pending   = occ;
  assign bus.grant_cnt = grant_cnt_r;
  assign bus.spurious  = spurious_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wait_cnt    <= '0;
      retried     <= 1'b0;
      req_r       <= 1'b0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      spurious_r  <= 1'b0;
      grant_cnt_r <= '0;
    end else begin
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      if (bus.gnt && !req_r) spurious_r <= 1'b1;

      case (state)
        IDLE: begin
          if (retried || (occ != '0)) begin
            req_r    <= 1'b1;
            wait_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus.gnt) begin
            req_r       <= 1'b0;
            done_r      <= 1'b1;
            grant_cnt_r <= sat_inc(grant_cnt_r);
            retried     <= 1'b0;
            state       <= GAP;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            req_r <= 1'b0;
            state <= GAP;
            if (RetryEn && !retried) begin
              retried <= 1'b1;
            end else begin
              timeout_r <= 1'b1;
              retried   <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
